// File: rtl/multi_clock_divider_if.sv
// Register-write and output bundle for multi_clock_divider.
// The master side drives enables and divisor writes; the slave side is the divider.
interface multi_clock_divider_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 32
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] en;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [DIV_W-1:0]  wr_div;
  logic [NUM_CH-1:0] clk_div;
  logic [NUM_CH-1:0] tick;

  modport master (
    output en, wr_en, wr_ch, wr_div,
    input  clk_div, tick
  );

  modport slave (
    input  en, wr_en, wr_ch, wr_div,
    output clk_div, tick
  );
endinterface

// File: rtl/multi_clock_divider.sv
// Runtime-programmable multi-channel clock divider / tick generator.
// Optional macro MULTI_CLKDIV_SYNC_EN adds a 'sync' input that phase-aligns all channels.
module multi_clock_divider #(
  parameter int          NUM_CH      = 4,
  parameter int          DIV_W       = 32,
  parameter int unsigned DEFAULT_DIV = 50000000
) (
  input logic clk,
  input logic rst,
`ifdef MULTI_CLKDIV_SYNC_EN
  input logic sync,
`endif
  multi_clock_divider_if.slave bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  logic [NUM_CH-1:0] clk_div_q;
  logic [NUM_CH-1:0] tick_q;

  assign bus.clk_div = clk_div_q;
  assign bus.tick    = tick_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] act;
    logic [DIV_W-1:0] pend;
    logic             wr_hit;
    logic             halted;
    logic             wrap;

    // Out-of-range channel numbers never match any channel, so they are dropped.
    assign wr_hit = bus.wr_en && (bus.wr_ch == CH_W'(i));
    assign halted = (act == '0);
    assign wrap   = !halted && (count == act - DIV_W'(1));

    // A new divisor only takes over at a period boundary; a write landing on
    // that very boundary bypasses pend so it is not delayed a whole period.
    always_ff @(posedge clk) begin
      if (rst) begin
        count        <= '0;
        act          <= DEF_DIV;
        pend         <= DEF_DIV;
        clk_div_q[i] <= 1'b0;
        tick_q[i]    <= 1'b0;
      end
`ifdef MULTI_CLKDIV_SYNC_EN
      else if (sync) begin
        count        <= '0;
        act          <= pend;
        clk_div_q[i] <= 1'b0;
        tick_q[i]    <= 1'b0;
        if (wr_hit) begin
          pend <= bus.wr_div;
        end
      end
`endif
      else begin
        tick_q[i] <= 1'b0;
        if (wr_hit) begin
          pend <= bus.wr_div;
        end
        if (bus.en[i]) begin
          if (halted) begin
            count <= '0;
            act   <= pend;
          end else if (wrap) begin
            count        <= '0;
            clk_div_q[i] <= ~clk_div_q[i];
            tick_q[i]    <= 1'b1;
            act          <= wr_hit ? bus.wr_div : pend;
          end else begin
            count <= count + DIV_W'(1);
          end
        end
      end
    end
  end

endmodule
